// File: rtl/load_store_unit.sv
// Load/store unit between a CPU request/response port and a single-cycle-read data memory.
// Sub-word stores are done as a read-modify-write over one extra cycle.
module load_store_unit #(
  parameter int unsigned MEM_WORDS = 64
) (
  input  logic        Clk,
  input  logic        Rst_n,
  input  logic        Req_Valid,
  output logic        Req_Ready,
  input  logic        Req_Write,
  input  logic [1:0]  Req_Size,
  input  logic        Req_Signed,
  input  logic [31:0] Req_Addr,
  input  logic [31:0] Req_WData,
  output logic        Rsp_Valid,
  input  logic        Rsp_Ready,
  output logic [31:0] Rsp_RData,
  output logic        Rsp_Fault,
  output logic [31:0] Mem_Addr,
  output logic        Mem_W_En,
  output logic [31:0] Mem_W_Data,
  input  logic [31:0] Mem_R_Data
);

  typedef enum logic [1:0] {IDLE, ACCESS, MERGE, RESP} state_e;

  state_e      state_q, state_d;
  logic        write_q, write_d;
  logic [1:0]  size_q, size_d;
  logic        signed_q, signed_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] word_q, word_d;
  logic [31:0] rdata_q, rdata_d;
  logic        fault_q, fault_d;

  logic        req_fault;
  logic [4:0]  lane_sh;
  logic [31:0] lane_word;
  logic [31:0] load_val;
  logic [31:0] lane_mask;
  logic [31:0] merged;

  always_comb begin
    req_fault = (Req_Size == 2'b11)
              | ((Req_Size == 2'b01) & Req_Addr[0])
              | ((Req_Size == 2'b10) & (|Req_Addr[1:0]))
              | ({2'b00, Req_Addr[31:2]} >= MEM_WORDS);
  end

  // Halfword accesses are 2-byte aligned, so one byte-offset shift serves both lane sizes.
  always_comb begin
    lane_sh   = {addr_q[1:0], 3'b000};
    lane_word = Mem_R_Data >> lane_sh;
    case (size_q)
      2'b00:   load_val = {{24{signed_q & lane_word[7]}}, lane_word[7:0]};
      2'b01:   load_val = {{16{signed_q & lane_word[15]}}, lane_word[15:0]};
      default: load_val = Mem_R_Data;
    endcase
    lane_mask = (size_q == 2'b00) ? 32'h0000_00FF : 32'h0000_FFFF;
    merged    = (word_q & ~(lane_mask << lane_sh)) | ((wdata_q & lane_mask) << lane_sh);
  end

  always_comb begin
    state_d  = state_q;
    write_d  = write_q;
    size_d   = size_q;
    signed_d = signed_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    word_d   = word_q;
    rdata_d  = rdata_q;
    fault_d  = fault_q;
    case (state_q)
      IDLE: begin
        if (Req_Valid) begin
          write_d  = Req_Write;
          size_d   = Req_Size;
          signed_d = Req_Signed;
          addr_d   = Req_Addr;
          wdata_d  = Req_WData;
          rdata_d  = '0;
          fault_d  = req_fault;
          state_d  = req_fault ? RESP : ACCESS;
        end
      end
      ACCESS: begin
        if (!write_q) begin
          rdata_d = load_val;
          state_d = RESP;
        end else if (size_q == 2'b10) begin
          state_d = RESP;
        end else begin
          word_d  = Mem_R_Data;
          state_d = MERGE;
        end
      end
      MERGE: state_d = RESP;
      RESP: begin
        if (Rsp_Ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q  <= IDLE;
      write_q  <= 1'b0;
      size_q   <= '0;
      signed_q <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      word_q   <= '0;
      rdata_q  <= '0;
      fault_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      write_q  <= write_d;
      size_q   <= size_d;
      signed_q <= signed_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      word_q   <= word_d;
      rdata_q  <= rdata_d;
      fault_q  <= fault_d;
    end
  end

  always_comb begin
    Req_Ready  = (state_q == IDLE);
    Rsp_Valid  = (state_q == RESP);
    Rsp_RData  = rdata_q;
    Rsp_Fault  = fault_q;
    Mem_Addr   = {addr_q[31:2], 2'b00};
    Mem_W_En   = 1'b0;
    Mem_W_Data = '0;
    if ((state_q == ACCESS) && write_q && (size_q == 2'b10)) begin
      Mem_W_En   = 1'b1;
      Mem_W_Data = wdata_q;
    end else if (state_q == MERGE) begin
      Mem_W_En   = 1'b1;
      Mem_W_Data = merged;
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: directed scenarios plus random traffic against a
// word-array reference memory that computes results with plain arithmetic.
module tb_load_store_unit;
  localparam int unsigned MEM_WORDS = 64;

  logic        Clk = 1'b0;
  logic        Rst_n;
  logic        Req_Valid, Req_Ready, Req_Write, Req_Signed;
  logic [1:0]  Req_Size;
  logic [31:0] Req_Addr, Req_WData;
  logic        Rsp_Valid, Rsp_Ready, Rsp_Fault;
  logic [31:0] Rsp_RData;
  logic [31:0] Mem_Addr, Mem_W_Data, Mem_R_Data;
  logic        Mem_W_En;

  load_store_unit #(.MEM_WORDS(MEM_WORDS)) dut (
    .Clk(Clk), .Rst_n(Rst_n),
    .Req_Valid(Req_Valid), .Req_Ready(Req_Ready), .Req_Write(Req_Write),
    .Req_Size(Req_Size), .Req_Signed(Req_Signed), .Req_Addr(Req_Addr),
    .Req_WData(Req_WData),
    .Rsp_Valid(Rsp_Valid), .Rsp_Ready(Rsp_Ready), .Rsp_RData(Rsp_RData),
    .Rsp_Fault(Rsp_Fault),
    .Mem_Addr(Mem_Addr), .Mem_W_En(Mem_W_En), .Mem_W_Data(Mem_W_Data),
    .Mem_R_Data(Mem_R_Data)
  );

  always #5 Clk = ~Clk;

  logic [31:0] mem      [MEM_WORDS];
  logic [31:0] init_mem [MEM_WORDS];
  logic [31:0] ref_mem  [MEM_WORDS];
  logic        init_en = 1'b0;

  always @(posedge Clk) begin
    if (init_en) begin
      for (int i = 0; i < int'(MEM_WORDS); i++) mem[i] <= init_mem[i];
    end else if (Mem_W_En && ({2'b00, Mem_Addr[31:2]} < MEM_WORDS)) begin
      mem[Mem_Addr[7:2]] <= Mem_W_Data;
    end
  end

  always_comb begin
    if ({2'b00, Mem_Addr[31:2]} < MEM_WORDS) Mem_R_Data = mem[Mem_Addr[7:2]];
    else Mem_R_Data = '0;
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Expected response / write for the transaction in flight
  logic        exp_active = 1'b0;
  logic        exp_fault;
  logic [31:0] exp_rdata, exp_wword, exp_waddr;
  int          wr_count = 0;

  always @(negedge Clk) begin
    if (Rst_n) begin
      if (Rsp_Valid && exp_active) begin
        chk("rsp_rdata", Rsp_RData, exp_rdata);
        chk("rsp_fault", {31'd0, Rsp_Fault}, {31'd0, exp_fault});
        chk("req_ready_in_resp", {31'd0, Req_Ready}, 32'd0);
      end
      if (Mem_W_En) begin
        wr_count++;
        chk("mem_w_data", Mem_W_Data, exp_wword);
        chk("mem_w_addr", Mem_Addr, exp_waddr);
      end
    end
  end

  // Reference: outcome of one access against ref_mem, from the access rules alone.
  task automatic model(input logic w, input logic [1:0] sz, input logic sg,
                       input logic [31:0] addr, input logic [31:0] wdata,
                       output logic fault, output logic [31:0] rdata,
                       output logic [31:0] wword, output int writes, output int lat);
    longint unsigned old, val, mask, nb, sh, nw;
    int idx;
    idx = int'(addr >> 2);
    fault = (sz == 2'd3) || (sz == 2'd1 && addr % 2 != 0) ||
            (sz == 2'd2 && addr % 4 != 0) || ((addr >> 2) >= MEM_WORDS);
    rdata = 0; wword = 0; writes = 0;
    if (fault) begin
      lat = 1;
      return;
    end
    nb   = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    sh   = 8 * longint'(addr % 4);
    mask = (64'd1 << (8 * nb)) - 1;
    old  = longint'(ref_mem[idx]);
    if (!w) begin
      val = (old >> sh) & mask;
      if (sg && nb < 4 && val >= (mask + 1) / 2) val = val + (64'hFFFF_FFFF - mask);
      rdata = val[31:0];
      lat = 2;
    end else begin
      nw = (old & ~(mask << sh)) | ((longint'(wdata) & mask) << sh);
      wword = nw[31:0];
      writes = 1;
      lat = (nb == 4) ? 2 : 3;
      ref_mem[idx] = wword;
    end
  endtask

  task automatic txn(input logic w, input logic [1:0] sz, input logic sg,
                     input logic [31:0] addr, input logic [31:0] wdata, input int hold,
                     output logic [31:0] got_rdata, output logic got_fault);
    int exp_writes, exp_lat, lat, g;
    model(w, sz, sg, addr, wdata, exp_fault, exp_rdata, exp_wword, exp_writes, exp_lat);
    exp_waddr  = {addr[31:2], 2'b00};
    wr_count   = 0;
    exp_active = 1'b1;
    @(negedge Clk);
    Req_Write = w; Req_Size = sz; Req_Signed = sg; Req_Addr = addr; Req_WData = wdata;
    Req_Valid = 1'b1;
    Rsp_Ready = (hold == 0);
    g = 0;
    while (!Req_Ready && g < 20) begin
      @(negedge Clk);
      g++;
    end
    if (!Req_Ready) chk("accept_timeout", 32'd0, 32'd1);
    @(posedge Clk);
    lat = 1;
    @(negedge Clk);
    Req_Valid = 1'b0;
    while (!Rsp_Valid && lat < 10) begin
      @(posedge Clk);
      lat++;
      @(negedge Clk);
    end
    chk("rsp_latency", lat, exp_lat);
    got_rdata = Rsp_RData;
    got_fault = Rsp_Fault;
    for (int i = 0; i < hold; i++) begin
      @(negedge Clk);
      chk("rsp_valid_held", {31'd0, Rsp_Valid}, 32'd1);
    end
    Rsp_Ready = 1'b1;
    @(posedge Clk);
    @(negedge Clk);
    Rsp_Ready = 1'b0;
    chk("rsp_valid_after_consume", {31'd0, Rsp_Valid}, 32'd0);
    chk("req_ready_after_consume", {31'd0, Req_Ready}, 32'd1);
    chk("write_pulses", wr_count, exp_writes);
    exp_active = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_req_ready"}, {31'd0, Req_Ready}, 32'd1);
    chk({tag, "_rsp_valid"}, {31'd0, Rsp_Valid}, 32'd0);
    chk({tag, "_rsp_fault"}, {31'd0, Rsp_Fault}, 32'd0);
    chk({tag, "_rsp_rdata"}, Rsp_RData, 32'd0);
    chk({tag, "_mem_w_en"},  {31'd0, Mem_W_En}, 32'd0);
    chk({tag, "_mem_w_data"}, Mem_W_Data, 32'd0);
    chk({tag, "_mem_addr"},  Mem_Addr, 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd, pf, pw;
    logic        fl, pfl;
    int          pwr, plat;
    logic [1:0]  sz;
    logic [31:0] a;

    Rst_n = 1'b0;
    Req_Valid = 1'b0; Req_Write = 1'b0; Req_Size = '0; Req_Signed = 1'b0;
    Req_Addr = '0; Req_WData = '0; Rsp_Ready = 1'b0;
    for (int i = 0; i < int'(MEM_WORDS); i++) init_mem[i] = $urandom;
    init_mem[2] = 32'h1122_3344;
    init_mem[3] = 32'h80FF_1234;
    for (int i = 0; i < int'(MEM_WORDS); i++) ref_mem[i] = init_mem[i];
    init_en = 1'b1;
    @(posedge Clk);
    #1 init_en = 1'b0;
    check_reset_outputs("reset");
    @(negedge Clk);
    Rst_n = 1'b1;

    // Pin the model with hand-derived values
    model(1'b0, 2'd0, 1'b1, 32'h0E, 32'd0, pfl, pf, pw, pwr, plat);
    chk("model_sbyte", pf, 32'hFFFF_FFFF);
    chk("model_sbyte_lat", plat, 32'd2);
    model(1'b1, 2'd2, 1'b0, 32'h0000_0102, 32'd0, pfl, pf, pw, pwr, plat);
    chk("model_misaligned_fault", {31'd0, pfl}, 32'd1);

    txn(1'b0, 2'd0, 1'b1, 32'h0E, 32'd0, 0, rd, fl);
    chk("sbyte_load", rd, 32'hFFFF_FFFF);
    txn(1'b0, 2'd0, 1'b0, 32'h0E, 32'd0, 0, rd, fl);
    chk("ubyte_load", rd, 32'h0000_00FF);

    txn(1'b1, 2'd1, 1'b0, 32'h0A, 32'h0000_ABCD, 0, rd, fl);
    chk("half_store_rsp", rd, 32'd0);
    @(negedge Clk);
    chk("half_store_mem", mem[2], 32'hABCD_3344);

    txn(1'b1, 2'd2, 1'b0, 32'h0000_0102, 32'h1234_5678, 0, rd, fl);
    chk("fault_misaligned_word", {31'd0, fl}, 32'd1);
    txn(1'b0, 2'd2, 1'b0, 32'h0000_0100, 32'd0, 0, rd, fl);
    chk("fault_out_of_range", {31'd0, fl}, 32'd1);
    txn(1'b0, 2'd3, 1'b0, 32'h0000_0000, 32'd0, 0, rd, fl);
    chk("fault_reserved_size", {31'd0, fl}, 32'd1);

    txn(1'b0, 2'd1, 1'b1, 32'h0E, 32'd0, 5, rd, fl);
    chk("backpressure_load", rd, 32'hFFFF_80FF);

    txn(1'b1, 2'd2, 1'b0, 32'h04, 32'hDEAD_BEEF, 0, rd, fl);
    txn(1'b0, 2'd2, 1'b0, 32'h04, 32'd0, 0, rd, fl);
    chk("b2b_word_load", rd, 32'hDEAD_BEEF);

    // Reset during ACCESS of a byte store: nothing may be written
    wr_count = 0;
    @(negedge Clk);
    Req_Write = 1'b1; Req_Size = 2'd0; Req_Signed = 1'b0;
    Req_Addr = 32'h15; Req_WData = 32'h77; Req_Valid = 1'b1;
    @(posedge Clk);
    #2 Rst_n = 1'b0;
    #1 check_reset_outputs("midop");
    @(negedge Clk);
    Req_Valid = 1'b0;
    @(negedge Clk);
    Rst_n = 1'b1;
    repeat (3) @(negedge Clk);
    chk("midop_no_write", wr_count, 32'd0);
    chk("midop_mem_word", mem[5], ref_mem[5]);

    for (int t = 0; t < 200; t++) begin
      sz = 2'($urandom_range(0, 3));
      a  = $urandom_range(0, MEM_WORDS * 4 + 7);
      if ($urandom_range(0, 2) != 0) begin
        if (sz == 2'd1) a[0] = 1'b0;
        if (sz == 2'd2) a[1:0] = 2'b00;
      end
      txn(1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), a, $urandom,
          $urandom_range(0, 3), rd, fl);
    end

    @(negedge Clk);
    for (int i = 0; i < int'(MEM_WORDS); i++) chk("final_mem", mem[i], ref_mem[i]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
